// File: rtl/mdio_master.sv
// MDIO Clause 22 management-frame engine.
// Takes one register read or write command per start/tr_end handshake,
// generates MDC from clock_50m and shifts the frame on the shared MDIO line.
// Completion is a level (tr_end) held until start drops, so a slow
// MDC-rate sequencer can observe it reliably.
module mdio_master #(
  parameter int MDC_DIV      = 1250,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clock_50m,
  input  logic        reset_n,
  input  logic        start,
  input  logic        if_read,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        tr_end,
  output logic [15:0] rd_data,
  output logic        read_err,
  output logic        mdc,
  inout  wire         mdio
);

  // Frame geometry: preamble, then ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16)
  localparam int FRAME_LEN = PREAMBLE_LEN + 32;
  localparam int DIV_W     = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(MDC_DIV - 1);
  localparam logic [6:0]       LAST_BIT   = 7'(FRAME_LEN - 1);
  localparam logic [6:0]       TA_FIRST   = 7'(PREAMBLE_LEN + 14);
  localparam logic [6:0]       TA_SECOND  = 7'(PREAMBLE_LEN + 15);
  localparam logic [6:0]       DATA_FIRST = 7'(PREAMBLE_LEN + 16);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    SHIFT,
    DONE
  } state_t;

  state_t                 state;
  logic [DIV_W-1:0]       div_cnt;
  logic                   div_wrap;
  logic                   fall_tick;
  logic                   rise_tick;
  logic [FRAME_LEN-1:0]   frame_sr;
  logic [6:0]             bit_idx;
  logic [6:0]             next_idx;
  logic                   is_read;
  logic [15:0]            shadow;
  logic                   mdio_oe;
  logic                   mdio_out;
  logic                   mdio_in;

  // The line is only ever driven while a frame bit is owned by the master;
  // otherwise the board pull-up sets the level.
  assign mdio    = mdio_oe ? mdio_out : 1'bz;
  assign mdio_in = mdio;

  // Ticks mark the clock_50m cycle at whose end mdc changes level.
  assign div_wrap  = (div_cnt == DIV_LAST);
  assign fall_tick = div_wrap & mdc;
  assign rise_tick = div_wrap & ~mdc;
  assign next_idx  = bit_idx + 7'd1;

  // Free-running MDC divider: toggle mdc every MDC_DIV system clocks.
  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      mdc     <= ~mdc;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame sequencer: latch command, shift bits on MDC falls, sample on rises.
  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      tr_end   <= 1'b0;
      rd_data  <= 16'h0000;
      read_err <= 1'b0;
      mdio_oe  <= 1'b0;
      mdio_out <= 1'b0;
      frame_sr <= '0;
      bit_idx  <= '0;
      is_read  <= 1'b0;
      shadow   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_read  <= if_read;
            frame_sr <= {{PREAMBLE_LEN{1'b1}},
                         2'b01,
                         (if_read ? 2'b10 : 2'b01),
                         phy_addr,
                         reg_addr,
                         (if_read ? 2'b11 : 2'b10),
                         (if_read ? 16'hFFFF : wr_data)};
            busy     <= 1'b1;
            state    <= WAIT_EDGE;
          end
        end

        WAIT_EDGE: begin
          if (fall_tick) begin
            mdio_out <= frame_sr[FRAME_LEN-1];
            frame_sr <= frame_sr << 1;
            mdio_oe  <= 1'b1;
            bit_idx  <= '0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (rise_tick && is_read) begin
            if (bit_idx == TA_SECOND) begin
              read_err <= (mdio_in != 1'b0);
            end
            if (bit_idx >= DATA_FIRST) begin
              shadow <= {shadow[14:0], mdio_in};
            end
          end
          if (fall_tick) begin
            if (bit_idx == LAST_BIT) begin
              mdio_oe <= 1'b0;
              tr_end  <= 1'b1;
              if (is_read) begin
                rd_data <= shadow;
              end
              state   <= DONE;
            end else begin
              bit_idx  <= next_idx;
              mdio_out <= frame_sr[FRAME_LEN-1];
              frame_sr <= frame_sr << 1;
              mdio_oe  <= ~(is_read && (next_idx >= TA_FIRST));
            end
          end
        end

        DONE: begin
          if (!start) begin
            tr_end <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Testbench for mdio_master with a fast MDC (MDC_DIV=4), a pull-up on the
// shared line and a small PHY model that answers read frames.
module tb_mdio_master;

  localparam int MDC_DIV      = 4;
  localparam int PREAMBLE_LEN = 32;
  localparam int LAT_MAX      = 2 * MDC_DIV * (PREAMBLE_LEN + 34);
  localparam int HOLD_CYCLES  = 10 * 2 * MDC_DIV;

  logic        clock_50m = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic        if_read   = 1'b0;
  logic [4:0]  phy_addr  = 5'h00;
  logic [4:0]  reg_addr  = 5'h00;
  logic [15:0] wr_data   = 16'h0000;
  logic        busy;
  logic        tr_end;
  logic [15:0] rd_data;
  logic        read_err;
  logic        mdc;
  wire         mdio;

  logic        phy_en   = 1'b0;
  logic [15:0] phy_data = 16'h0000;
  logic        phy_oe   = 1'b0;
  logic        phy_out  = 1'b0;
  logic        phy_resp = 1'b0;
  logic        phy_last = 1'b1;
  logic [13:0] phy_hdr  = '0;
  int          phy_hdr_cnt = 0;
  int          phy_fall    = 0;

  logic [63:0] wire_bits = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        is_rd;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic        phy_on;
    logic [15:0] phy_rsp;
    logic [63:0] exp_frame;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  pullup pu_mdio (mdio);
  assign mdio = phy_oe ? phy_out : 1'bz;

  mdio_master #(
    .MDC_DIV      (MDC_DIV),
    .PREAMBLE_LEN (PREAMBLE_LEN)
  ) dut (
    .clock_50m (clock_50m),
    .reset_n   (reset_n),
    .start     (start),
    .if_read   (if_read),
    .phy_addr  (phy_addr),
    .reg_addr  (reg_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .tr_end    (tr_end),
    .rd_data   (rd_data),
    .read_err  (read_err),
    .mdc       (mdc),
    .mdio      (mdio)
  );

  // 50 MHz system clock.
  always #10 clock_50m = ~clock_50m;

  // Record the line level at every MDC rise, as a PHY would see it.
  always @(posedge mdc) wire_bits <= {wire_bits[62:0], mdio};

  // PHY model: decode a read header on rises, drive TA=0 and data on falls.
  always @(mdc) begin
    if (mdc) begin
      if (!phy_en) begin
        phy_hdr_cnt = 0;
        phy_resp    = 1'b0;
        phy_last    = 1'b1;
        phy_oe      = 1'b0;
      end else if (!phy_resp) begin
        if (phy_hdr_cnt == 0) begin
          if (mdio == 1'b0 && phy_last == 1'b1) begin
            phy_hdr     = 14'b0;
            phy_hdr_cnt = 1;
          end
        end else begin
          phy_hdr     = {phy_hdr[12:0], mdio};
          phy_hdr_cnt = phy_hdr_cnt + 1;
          if (phy_hdr_cnt == 14) begin
            phy_hdr_cnt = 0;
            if (phy_hdr[13:10] == 4'b0110) begin
              phy_resp = 1'b1;
              phy_fall = 0;
            end
          end
        end
        phy_last = mdio;
      end
    end else if (phy_resp) begin
      phy_fall = phy_fall + 1;
      if (phy_fall == 2) begin
        phy_oe  = 1'b1;
        phy_out = 1'b0;
      end else if (phy_fall >= 3 && phy_fall <= 18) begin
        phy_out = phy_data[18 - phy_fall];
      end else if (phy_fall == 19) begin
        phy_oe   = 1'b0;
        phy_resp = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int  cyc;
    bit  seen;
    bit  hold_ok;
    @(negedge clock_50m);
    phy_en   = v.phy_on;
    phy_data = v.phy_rsp;
    if_read  = v.is_rd;
    phy_addr = v.phy;
    reg_addr = v.regad;
    wr_data  = v.wdata;
    start    = 1'b1;
    seen     = 1'b0;
    cyc      = 0;
    @(negedge clock_50m);
    cyc = 1;
    checkOutput($sformatf("v%0d_busy_after_start", idx), {63'b0, busy}, 64'd1);
    // Scramble the command inputs: the latched copy must be used.
    phy_addr = ~v.phy;
    reg_addr = ~v.regad;
    wr_data  = ~v.wdata;
    if_read  = ~v.is_rd;
    while (cyc < 2 * LAT_MAX && !seen) begin
      if (tr_end) begin
        seen = 1'b1;
      end else begin
        @(negedge clock_50m);
        cyc = cyc + 1;
      end
    end
    checkOutput($sformatf("v%0d_tr_end_in_time", idx),
                {63'b0, (seen && cyc <= LAT_MAX)}, 64'd1);
    checkOutput($sformatf("v%0d_frame", idx), wire_bits, v.exp_frame);
    checkOutput($sformatf("v%0d_rd_data", idx), {48'b0, rd_data}, {48'b0, v.exp_rd});
    checkOutput($sformatf("v%0d_read_err", idx), {63'b0, read_err}, {63'b0, v.exp_err});
    hold_ok = 1'b1;
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      @(negedge clock_50m);
      if (!(tr_end && busy)) hold_ok = 1'b0;
    end
    checkOutput($sformatf("v%0d_hold_done", idx), {63'b0, hold_ok}, 64'd1);
    start = 1'b0;
    @(negedge clock_50m);
    checkOutput($sformatf("v%0d_release", idx), {62'b0, tr_end, busy}, 64'd0);
    phy_en = 1'b0;
    repeat (2 * MDC_DIV * 3) @(negedge clock_50m);
  endtask

  initial begin
    logic s[48];
    int   rise_at;
    int   wave_err;
    int   falls;
    logic prev;
    bit   late_tr_end;

    vecs[0] = '{1'b0, 5'h01, 5'h00, 16'h1340, 1'b0, 16'h0000,
                64'hFFFF_FFFF_5082_1340, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 5'h01, 5'h01, 16'h0000, 1'b1, 16'h796D,
                64'hFFFF_FFFF_6086_796D, 16'h796D, 1'b0};
    vecs[2] = '{1'b0, 5'h1F, 5'h1F, 16'hA5A5, 1'b0, 16'h0000,
                64'hFFFF_FFFF_5FFE_A5A5, 16'h796D, 1'b0};
    vecs[3] = '{1'b1, 5'h01, 5'h01, 16'h0000, 1'b0, 16'h0000,
                64'hFFFF_FFFF_6087_FFFF, 16'hFFFF, 1'b1};
    vecs[4] = '{1'b0, 5'h00, 5'h04, 16'h01E1, 1'b0, 16'h0000,
                64'hFFFF_FFFF_5012_01E1, 16'hFFFF, 1'b1};
    vecs[5] = '{1'b1, 5'h12, 5'h0A, 16'h0000, 1'b1, 16'h0001,
                64'hFFFF_FFFF_692A_0001, 16'h0001, 1'b0};

    // Reset state
    repeat (5) @(negedge clock_50m);
    checkOutput("reset_outputs", {44'b0, mdc, busy, tr_end, read_err, rd_data},
                64'd0);
    checkOutput("reset_mdio_released", {63'b0, mdio}, 64'd1);
    reset_n = 1'b1;

    // MDC waveform: period 8 clocks, 4 high / 4 low
    for (int i = 0; i < 48; i++) begin
      @(negedge clock_50m);
      s[i] = mdc;
    end
    rise_at = -1;
    for (int i = 1; i < 10; i++) begin
      if (rise_at < 0 && !s[i-1] && s[i]) rise_at = i;
    end
    wave_err = 0;
    if (rise_at < 0) begin
      wave_err = 99;
    end else begin
      for (int k = 0; k < 32; k++) begin
        if (s[rise_at + k] != ((k % 8) < 4)) wave_err = wave_err + 1;
      end
    end
    checkOutput("mdc_wave_errors", 64'(wave_err), 64'd0);
    checkOutput("idle_outputs", {45'b0, busy, tr_end, read_err, rd_data}, 64'd0);

    // Reset in the middle of a write, while bit 40 (PHYAD[0]=0) is driven
    @(negedge clock_50m);
    if_read  = 1'b0;
    phy_addr = 5'h00;
    reg_addr = 5'h04;
    wr_data  = 16'h0000;
    start    = 1'b1;
    @(posedge clock_50m);
    #1;
    prev  = mdc;
    falls = 0;
    for (int c = 0; c < 2000 && falls < 41; c++) begin
      @(posedge clock_50m);
      #1;
      if (prev && !mdc) falls = falls + 1;
      prev = mdc;
    end
    checkOutput("mid_reach_bit40", 64'(falls), 64'd41);
    #30;
    checkOutput("mid_bit40_driven_low", {63'b0, mdio}, 64'd0);
    checkOutput("mid_busy_before", {63'b0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_mdio_released", {63'b0, mdio}, 64'd1);
    checkOutput("mid_busy_cleared", {62'b0, busy, tr_end}, 64'd0);
    start = 1'b0;
    repeat (3) @(negedge clock_50m);
    reset_n = 1'b1;
    late_tr_end = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock_50m);
      if (tr_end || busy) late_tr_end = 1'b1;
    end
    checkOutput("mid_no_tr_end", {63'b0, late_tr_end}, 64'd0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
MDIO management-frame engine (IEEE 802.3 Clause 22) that sits directly downstream of the PHY register configuration sequencer. It accepts one register write or read command per handshake and generates MDC. It serialises the frame on the bidirectional MDIO line and returns read data plus a completion flag. The completion handshake is level-based, so a sequencer clocked at MDC rate (20 kHz) can observe it.

Parameters:
MDC_DIV, 1250, clock_50m cycles per MDC half-period (1250 gives 20 kHz MDC).
PREAMBLE_LEN, 32, number of preamble '1' bits per frame (legal range 1..32).

Ports:
clock_50m  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous, active-low reset
start  in  1  command request, level; held high until tr_end is seen
if_read  in  1  1 = read frame (OP=10), 0 = write frame (OP=01); sampled with start
phy_addr  in  5  PHY address (PHYAD)
reg_addr  in  5  register address (REGAD)
wr_data  in  16  write payload
busy  out  1  frame in progress or completion pending
tr_end  out  1  completion flag, level
rd_data  out  16  last read result, MSB first on the wire
read_err  out  1  PHY did not drive TA low on the last read
mdc  out  1  management clock
mdio  inout  1  management data; driven when enabled, otherwise 'z'

Behaviour:
- Reset values:
  - mdc=0, mdio='z', busy=0, tr_end=0, rd_data=16'h0000, read_err=0.
  - The MDC divider counter clears; the FSM goes to IDLE.
- MDC generation:
  - A free-running counter toggles mdc every MDC_DIV clock_50m cycles.
  - fall_tick is the clock_50m cycle in which mdc goes 1->0; rise_tick is the cycle in which mdc goes 0->1.
- FSM states: IDLE, WAIT_EDGE, SHIFT, DONE.
- IDLE:
  - When start=1, latch if_read, phy_addr, reg_addr and wr_data.
  - Set busy=1 on the next clock and go to WAIT_EDGE.
  - Input changes after the latch are ignored until IDLE is re-entered.
- WAIT_EDGE: on the next fall_tick, drive bit 0 and go to SHIFT.
- SHIFT, frame length N=PREAMBLE_LEN+32 bits, index k=0..N-1:
  - Bit k is driven on fall_tick; the PHY samples on the following rising edge.
  - Frame order: PREAMBLE_LEN x '1', ST=01, OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], each field MSB first.
  - Write frame: TA=10, DATA=wr_data; mdio is driven for the whole frame.
  - Read frame: mdio is released ('z') from the fall_tick of the first TA bit through the end of the frame.
    - At the rise_tick of the second TA bit, sample mdio; read_err=1 if it is not 0, else 0.
    - At each rise_tick of DATA bits 15..0, shift mdio into a shadow register.
    - rd_data loads from the shadow register when the frame ends; rd_data is updated even when read_err=1.
  - A write frame leaves rd_data and read_err unchanged.
- End of frame: on the fall_tick after bit N-1, release mdio, set tr_end=1 and go to DONE.
- DONE:
  - Hold tr_end=1 and busy=1 while start=1.
  - When start=0, clear tr_end and busy on the next clock and return to IDLE.
  - A new frame can never start while the previous start is still held.
- Latency: from start accepted to tr_end=1 is at most 2*MDC_DIV*(N+2) clock_50m cycles, i.e. 64 MDC periods plus edge alignment for the default preamble.
- Idle line: mdio is 'z' whenever not in SHIFT; the board pull-up defines the idle level.
- Reset mid-frame: mdio releases immediately (asynchronous); tr_end is never asserted for the aborted frame.
- Simultaneous events:
  - start rising in the same cycle as a fall_tick in IDLE: the latch happens, and the frame begins on the next fall_tick, not the current one.
  - start dropping in DONE in the same cycle as a tick: the tick is irrelevant, and the return to IDLE proceeds as normal.

Test Plan:
- MDC_DIV=4: after reset, mdc period = 8 clock_50m cycles with 50% duty; mdio='z'; all outputs at reset values.
- Write phy_addr=1, reg_addr=0x00, wr_data=0x1340, MDC_DIV=4 -> bits captured at MDC rising edges are 32x'1', 01 01 00001 00000 10, then 0x1340. tr_end=1 within 2*4*66 cycles; rd_data stays 0x0000.
- Read phy_addr=1, reg_addr=0x01 against a PHY model that drives TA=0 and data 0x796D -> OP=10; mdio is released from TA onward; rd_data=0x796D; read_err=0.
- Read with no PHY (pull-up only) -> rd_data=0xFFFF, read_err=1, tr_end still asserts.
- Hold start high for 10 MDC periods after tr_end -> tr_end and busy stay 1 and no second frame appears. Drop start -> tr_end=0 and busy=0 one clock later.
- Assert reset_n=0 at frame bit 40 -> mdio='z' and busy=0 immediately. A subsequent write completes with a correct frame.
